param_readback_tx: RTL and testbench

//  Host-bound side of the LabView serial link: on request, snapshots the live pulse-parameter
//  set and serialises it as a framed 8N1 UART byte stream on the FTDI transmit pin. Sits beside
//  the parameter receiver and shares its parameter buses, so the host can verify what the

---
 rtl/param_readback_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_param_readback_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_readback_tx.sv
// Snapshots the pulse-parameter set on request and sends it to the host as framed 8N1 UART bytes.
// Define CHECKSUM_EN to append an XOR checksum byte over the payload (HEADER excluded).
module param_readback_tx #(
    parameter int          CLK_HZ = 12000000,
    parameter int          BAUD   = 9600,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [23:0] per,
    input  logic [15:0] p1wid,
    input  logic [15:0] del,
    input  logic [15:0] p2wid,
    input  logic [15:0] nut_d,
    input  logic [7:0]  nut_w,
    input  logic        nut,
    input  logic        pu,
    input  logic        bl,
    input  logic [7:0]  cp,
    input  logic [7:0]  p_bl,
    input  logic [15:0] p_bl_off,
    output logic        RS232_Tx,
    output logic        busy,
    output logic        done
);

    // state   | meaning
    // S_IDLE  | line high, waiting for start
    // S_LOAD  | shadow captured, first byte being fetched
    // S_START | start bit (low)
    // S_DATA  | 8 data bits, LSB first
    // S_STOP  | stop bit (high), then next byte or frame end

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
`ifdef CHECKSUM_EN
    localparam logic [4:0] LAST_IDX = 5'd18;
`else
    localparam logic [4:0] LAST_IDX = 5'd17;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic       rst_meta_q;
    logic       rst_sync_q;
    logic       rst_n;

    state_t     state_q,    state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q,  bit_idx_d;
    logic [4:0] byte_idx_q, byte_idx_d;
    logic [7:0] shift_q,    shift_d;
    logic [135:0] shadow_q, shadow_d;
    logic       tx_q,       tx_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic [4:0] byte_idx_nxt;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n = rst_sync_q;

    // Shadow is kept in wire order: payload byte k (1..17) sits at [(17-k)*8 +: 8].
`ifdef CHECKSUM_EN
    function automatic logic [7:0] payload_xor(input logic [135:0] sh);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 17; k++) begin
            x = x ^ sh[k*8 +: 8];
        end
        return x;
    endfunction
`endif

    function automatic logic [7:0] frame_byte(input logic [4:0] idx, input logic [135:0] sh);
        logic [7:0] b;
        b = HEADER;
        for (int k = 1; k <= 17; k++) begin
            if (idx == 5'(k)) begin
                b = sh[(17-k)*8 +: 8];
            end
        end
`ifdef CHECKSUM_EN
        if (idx == 5'd18) begin
            b = payload_xor(sh);
        end
`endif
        return b;
    endfunction

    assign byte_idx_nxt = (byte_idx_q >= LAST_IDX) ? LAST_IDX : byte_idx_q + 5'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        shadow_d   = shadow_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d    = S_LOAD;
                    byte_idx_d = 5'd0;
                    shadow_d   = {per, p1wid, del, p2wid, nut_d, nut_w,
                                  5'b0, bl, pu, nut, cp, p_bl, p_bl_off};
                end
            end
            S_LOAD: begin
                state_d = S_START;
                cnt_d   = CNT_RELOAD;
                shift_d = frame_byte(byte_idx_q, shadow_q);
                tx_d    = 1'b0;
                busy_d  = 1'b1;
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d   = S_DATA;
                    cnt_d     = CNT_RELOAD;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        // Next byte follows the stop bit with no idle gap.
                        state_d    = S_START;
                        cnt_d      = CNT_RELOAD;
                        byte_idx_d = byte_idx_nxt;
                        shift_d    = frame_byte(byte_idx_nxt, shadow_q);
                        tx_d       = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 5'd0;
            shift_q    <= 8'h00;
            shadow_q   <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            shadow_q   <= shadow_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign RS232_Tx = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_param_readback_tx.sv
// Bench for param_readback_tx at 4 clocks per bit; decodes the UART line and checks framing and timing.
module tb_param_readback_tx;

`ifdef CHECKSUM_EN
    localparam int NB = 19;
`else
    localparam int NB = 18;
`endif
    localparam int BIT_CLKS = 4;

    typedef struct {
        logic [23:0]  per;
        logic [15:0]  p1wid;
        logic [15:0]  del;
        logic [15:0]  p2wid;
        logic [15:0]  nut_d;
        logic [7:0]   nut_w;
        logic         nut;
        logic         pu;
        logic         bl;
        logic [7:0]   cp;
        logic [7:0]   p_bl;
        logic [15:0]  p_bl_off;
        logic [151:0] exp;   // frame bytes in wire order, byte 0 in the top 8 bits
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [23:0] per;
    logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
    logic [7:0]  nut_w, cp, p_bl;
    logic        nut, pu, bl;
    logic        RS232_Tx, busy, done;

    int checks = 0;
    int errors = 0;
    int busy_tot = 0;
    int done_tot = 0;
    int low_tot = 0;

    vec_t vecs [5];

    param_readback_tx #(
        .CLK_HZ (12000000),
        .BAUD   (3000000),
        .HEADER (8'hA5)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .per      (per),
        .p1wid    (p1wid),
        .del      (del),
        .p2wid    (p2wid),
        .nut_d    (nut_d),
        .nut_w    (nut_w),
        .nut      (nut),
        .pu       (pu),
        .bl       (bl),
        .cp       (cp),
        .p_bl     (p_bl),
        .p_bl_off (p_bl_off),
        .RS232_Tx (RS232_Tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_tot++;
        if (done === 1'b1) done_tot++;
        if (RS232_Tx !== 1'b1) low_tot++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        per = v.per; p1wid = v.p1wid; del = v.del; p2wid = v.p2wid;
        nut_d = v.nut_d; nut_w = v.nut_w; nut = v.nut; pu = v.pu; bl = v.bl;
        cp = v.cp; p_bl = v.p_bl; p_bl_off = v.p_bl_off;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Waits for a start bit (lat = negedges waited) then samples every cycle of every bit.
    task automatic capture(output logic [151:0] got, output int lat, output int glitch, output bit to);
        logic       s0;
        logic [7:0] b;
        got = '0; lat = 0; glitch = 0; to = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (RS232_Tx !== 1'b0 && lat < 60);
        if (RS232_Tx !== 1'b0) begin
            to = 1'b1;
            return;
        end
        for (int k = 0; k < NB; k++) begin
            b = 8'h00;
            for (int i = 0; i < 10; i++) begin
                if (!(k == 0 && i == 0)) @(negedge clk);
                s0 = RS232_Tx;
                for (int c = 1; c < BIT_CLKS; c++) begin
                    @(negedge clk);
                    if (RS232_Tx !== s0) glitch++;
                end
                if (i == 0) begin
                    if (s0 !== 1'b0) glitch++;
                end else if (i == 9) begin
                    if (s0 !== 1'b1) glitch++;
                end else begin
                    b = {s0, b[7:1]};
                end
            end
            got[151-8*k -: 8] = b;
        end
    endtask

    task automatic chk_bytes(input string tag, input logic [151:0] got, input logic [151:0] exp);
        for (int k = 0; k < NB; k++) begin
            chk($sformatf("%s byte%0d", tag, k), {24'h0, got[151-8*k -: 8]}, {24'h0, exp[151-8*k -: 8]});
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        logic [151:0] got;
        int lat, gl, b0, d0;
        bit to;
        apply(v);
        b0 = busy_tot;
        d0 = done_tot;
        pulse_start();
        capture(got, lat, gl, to);
        chk({tag, " timeout"}, {31'h0, to}, 32'h0);
        chk({tag, " latency"}, lat, 2);
        chk({tag, " bit width"}, gl, 0);
        chk_bytes(tag, got, v.exp);
        @(negedge clk);
        chk({tag, " done at end"}, {31'h0, done}, 32'h1);
        chk({tag, " busy at end"}, {31'h0, busy}, 32'h0);
        chk({tag, " tx at end"}, {31'h0, RS232_Tx}, 32'h1);
        repeat (3) @(negedge clk);
        chk({tag, " busy cycles"}, busy_tot - b0, NB * 10 * BIT_CLKS);
        chk({tag, " done pulses"}, done_tot - d0, 1);
    endtask

    initial begin
        logic [151:0] got;
        int lat, gl, bad_tx, bad_busy, bad_done, d0, l0;
        bit to;

        vecs[0] = '{24'h123456, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 16'h0,
                    {8'hA5, 8'h12, 8'h34, 8'h56, {14{8'h00}}, 8'h70}};
        vecs[1] = '{24'h000001, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 16'h0,
                    {8'hA5, 8'h00, 8'h00, 8'h01, {14{8'h00}}, 8'h01}};
        vecs[2] = '{24'h000001, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 16'h0,
                    {8'hA5, 8'h00, 8'h00, 8'h01, {9{8'h00}}, 8'h03, {4{8'h00}}, 8'h02}};
        vecs[3] = '{24'hABCDEF, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 8'h09, 1'b1, 1'b0, 1'b1,
                    8'h0A, 8'h0B, 16'h0C0D,
                    {8'hA5, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                     8'h07, 8'h08, 8'h09, 8'h05, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h8D}};
        vecs[4] = '{24'hFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b1,
                    8'hFF, 8'hFF, 16'hFFFF,
                    {8'hA5, {12{8'hFF}}, 8'h07, {4{8'hFF}}, 8'h07}};

        resetn = 1'b0;
        start  = 1'b0;
        apply('{24'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 16'h0, 152'h0});
        repeat (3) @(negedge clk);
        chk("reset tx", {31'h0, RS232_Tx}, 32'h1);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset done", {31'h0, done}, 32'h0);
        @(posedge clk); #2 resetn = 1'b1;

        // Idle line with no start request
        bad_tx = 0; bad_busy = 0; bad_done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (RS232_Tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (done !== 1'b0) bad_done++;
        end
        chk("idle tx", bad_tx, 0);
        chk("idle busy", bad_busy, 0);
        chk("idle done", bad_done, 0);

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v], $sformatf("vec%0d", v));
        end

        // Re-request and input changes mid-frame must not disturb the latched frame
        apply(vecs[3]);
        d0 = done_tot;
        pulse_start();
        fork
            capture(got, lat, gl, to);
            begin
                repeat (300) @(posedge clk);
                #1 start = 1'b1;
                apply(vecs[4]);
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        chk("midreq timeout", {31'h0, to}, 32'h0);
        chk("midreq bit width", gl, 0);
        chk_bytes("midreq", got, vecs[3].exp);
        l0 = low_tot;
        repeat (NB * 10 * BIT_CLKS + 20) @(negedge clk);
        chk("midreq no second frame", low_tot - l0, 0);
        chk("midreq done pulses", done_tot - d0, 1);

        // Reset in the middle of a frame
        apply(vecs[3]);
        pulse_start();
        repeat (200) @(posedge clk);
        #3;
        chk("midreset busy before", {31'h0, busy}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("midreset tx", {31'h0, RS232_Tx}, 32'h1);
        chk("midreset busy", {31'h0, busy}, 32'h0);
        chk("midreset done", {31'h0, done}, 32'h0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (4) @(posedge clk);
        run_frame(vecs[3], "after reset");

        // start held high: consecutive frames
        apply(vecs[0]);
        d0 = done_tot;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        capture(got, lat, gl, to);
        chk("held f1 timeout", {31'h0, to}, 32'h0);
        chk("held f1 latency", lat, 2);
        chk("held f1 bit width", gl, 0);
        chk_bytes("held f1", got, vecs[0].exp);
        fork
            capture(got, lat, gl, to);
            begin
                repeat (20) @(posedge clk);
                #1 start = 1'b0;
            end
        join
        chk("held f2 timeout", {31'h0, to}, 32'h0);
        chk("held gap", lat, 3);
        chk("held f2 bit width", gl, 0);
        chk_bytes("held f2", got, vecs[0].exp);
        l0 = low_tot;
        repeat (100) @(negedge clk);
        chk("held stops after release", low_tot - l0, 0);
        chk("held done pulses", done_tot - d0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
